// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD serial transmitter: digit geometry and FSM state encoding.
// The PAR state exists only when BCD_TX_PARITY_EN is defined.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam int BCD_MAX     = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
`ifdef BCD_TX_PARITY_EN
      ST_PAR   = 2'd2,
`endif
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_digit_check.sv
// Flags a single 4-bit value that is not a legal BCD digit (greater than nine).
module bcd_digit_check
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic                   o_invalid
);

   assign o_invalid = (i_digit > BCD_DIGIT_W'(BCD_MAX));

endmodule

// File: rtl/bcd_tx.sv
// Serialises DIGITS packed BCD digits MSB first with a one-cycle done pulse and sticky load error.
// Define BCD_TX_PARITY_EN to append one odd-parity bit after the data bits.
module bcd_tx
   import bcd_pkg::*;
#(
   parameter int   DIGITS     = 2,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_syn,
   input  logic                          load,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] Din,
   output logic                          Dout,
   output logic                          Dvalid,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [BCD_DIGIT_W-1:0]        Q
);

   localparam int         DW       = BCD_DIGIT_W * DIGITS;
   localparam logic [4:0] LAST_BIT = 5'(DW - 1);

   state_t                 r_state;
   logic [DW-1:0]          r_data;
   logic [DW-1:0]          r_shift;
   logic [4:0]             r_bitcnt;
   logic                   r_dout;
   logic                   r_dvalid;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;
   logic [BCD_DIGIT_W-1:0] r_q;
`ifdef BCD_TX_PARITY_EN
   logic                   r_par;
`endif

   logic [DIGITS-1:0]      w_bad;
   logic [4:0]             w_next_cnt;
   logic [BCD_DIGIT_W-1:0] w_next_q;

   for (genvar g = 0; g < DIGITS; g++) begin : g_chk
      bcd_digit_check u_chk (
         .i_digit   (Din[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_invalid (w_bad[g])
      );
   end

   // Digit that will be on the line after the next shift; index counts down from the MSD.
   // NOTE: every signal driven from always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_next_cnt = r_bitcnt + 5'd1;
      w_next_q   = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (int'(w_next_cnt[4:2]) == DIGITS - 1 - d)
            w_next_q = r_data[d*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
   end

   // r_shift holds the bits still to send, so Dout is always loaded from its MSB.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst_syn) begin
      if (rst_syn) begin
         r_state  <= ST_IDLE;
         r_data   <= '0;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_dout   <= IDLE_LEVEL;
         r_dvalid <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_q      <= '0;
`ifdef BCD_TX_PARITY_EN
         r_par    <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  if (|w_bad) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state  <= ST_SHIFT;
                     r_data   <= Din;
                     r_shift  <= {Din[DW-2:0], 1'b0};
                     r_bitcnt <= '0;
                     r_err    <= 1'b0;
                     r_dout   <= Din[DW-1];
                     r_dvalid <= 1'b1;
                     r_busy   <= 1'b1;
                     r_q      <= Din[DW-1 -: BCD_DIGIT_W];
`ifdef BCD_TX_PARITY_EN
                     r_par    <= ~^Din;
`endif
                  end
               end
            end
            ST_SHIFT: begin
               if (r_bitcnt == LAST_BIT) begin
                  r_q <= '0;
`ifdef BCD_TX_PARITY_EN
                  r_state  <= ST_PAR;
                  r_dout   <= r_par;
`else
                  r_state  <= ST_DONE;
                  r_dout   <= IDLE_LEVEL;
                  r_dvalid <= 1'b0;
                  r_done   <= 1'b1;
`endif
               end else begin
                  r_bitcnt <= w_next_cnt;
                  r_shift  <= {r_shift[DW-2:0], 1'b0};
                  r_dout   <= r_shift[DW-1];
                  r_q      <= w_next_q;
               end
            end
`ifdef BCD_TX_PARITY_EN
            ST_PAR: begin
               r_state  <= ST_DONE;
               r_dout   <= IDLE_LEVEL;
               r_dvalid <= 1'b0;
               r_done   <= 1'b1;
            end
`endif
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Dout   = r_dout;
   assign Dvalid = r_dvalid;
   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;
   assign Q      = r_q;

endmodule

// File: tb/tb_bcd_tx.sv
// Directed self-checking bench for bcd_tx (DIGITS=2, IDLE_LEVEL=0); parity-aware via BCD_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_bcd_tx;

   logic       clk = 1'b0;
   logic       rst_syn;
   logic       load;
   logic [7:0] Din;
   logic       Dout, Dvalid, busy, done, err;
   logic [3:0] Q;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_tx #(.DIGITS(2), .IDLE_LEVEL(1'b0)) dut (
      .clk    (clk),
      .rst_syn(rst_syn),
      .load   (load),
      .Din    (Din),
      .Dout   (Dout),
      .Dvalid (Dvalid),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .Q      (Q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one frame and checks every bit cycle; leaves the bench sampled in the done cycle.
   task automatic send_frame(input string name, input logic [7:0] din, input logic [7:0] bits,
                             input logic [3:0] q_hi, input logic [3:0] q_lo, input logic par,
                             input bit hold, input bit inject);
      load = 1'b1;
      Din  = din;
      step();
      if (!hold) load = 1'b0;
      check({name, " err cleared"}, err, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s bit%0d", name, i), Dout, bits[7-i]);
         check($sformatf("%s valid%0d", name, i), Dvalid, 1'b1);
         check($sformatf("%s busy%0d", name, i), busy, 1'b1);
         check($sformatf("%s nodone%0d", name, i), done, 1'b0);
         check($sformatf("%s q%0d", name, i), Q, (i < 4) ? q_hi : q_lo);
         if (inject && i == 3) begin
            load = 1'b1;
            Din  = 8'h99;
         end
         if (inject && i == 5) load = 1'b0;
         step();
      end
`ifdef BCD_TX_PARITY_EN
      check({name, " parity"}, Dout, par);
      check({name, " parity valid"}, Dvalid, 1'b1);
      check({name, " parity nodone"}, done, 1'b0);
      step();
`else
      if (par) ;
`endif
      check({name, " done"}, done, 1'b1);
      check({name, " done busy"}, busy, 1'b1);
      check({name, " done valid"}, Dvalid, 1'b0);
   endtask

   initial begin
      rst_syn = 1'b1;
      load    = 1'b0;
      Din     = 8'h00;
      #2;
      check("rst dout", Dout, 1'b0);
      check("rst valid", Dvalid, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst err", err, 1'b0);
      check("rst q", Q, 4'd0);
      step();
      step();
      rst_syn = 1'b0;

      // Plain frame 8'h42: bits 0100_0010, odd parity bit 1.
      send_frame("f42", 8'h42, 8'b0100_0010, 4'd4, 4'd2, 1'b1, 1'b0, 1'b0);
      step();
      check("f42 idle busy", busy, 1'b0);
      check("f42 idle done", done, 1'b0);

      // Illegal digit 0xA: rejected, sticky error, nothing sent.
      load = 1'b1;
      Din  = 8'h3A;
      step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bad err%0d", i), err, 1'b1);
         check($sformatf("bad busy%0d", i), busy, 1'b0);
         check($sformatf("bad valid%0d", i), Dvalid, 1'b0);
         check($sformatf("bad dout%0d", i), Dout, 1'b0);
         step();
      end

      // Load of 8'h99 mid-frame must be ignored.
      send_frame("inj", 8'h42, 8'b0100_0010, 4'd4, 4'd2, 1'b1, 1'b0, 1'b1);
      step();
      check("inj idle valid", Dvalid, 1'b0);
      check("inj idle busy", busy, 1'b0);

      // Reset after bit 3 aborts the frame immediately.
      load = 1'b1;
      Din  = 8'h42;
      step();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("abort bit%0d", i), Dout, 8'b0100_0010 >> (7 - i) & 8'h1);
         step();
      end
      #2;
      rst_syn = 1'b1;
      #1;
      check("abort valid", Dvalid, 1'b0);
      check("abort busy", busy, 1'b0);
      check("abort q", Q, 4'd0);
      check("abort dout", Dout, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("abort nodone%0d", i), done, 1'b0);
      end
      rst_syn = 1'b0;
      // Load is presented for the first edge after reset release; ones=3 so parity bit 0.
      send_frame("f15", 8'h15, 8'b0001_0101, 4'd1, 4'd5, 1'b0, 1'b0, 1'b0);
      step();

      // Load held high: second frame's first bit two cycles after done.
      send_frame("b2b", 8'h09, 8'b0000_1001, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0);
      step();
      check("b2b gap valid", Dvalid, 1'b0);
      check("b2b gap busy", busy, 1'b0);
      step();
      check("b2b f2 valid", Dvalid, 1'b1);
      check("b2b f2 bit0", Dout, 1'b0);
      check("b2b f2 q", Q, 4'd0);
      load = 1'b0;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
         end
         check("b2b f2 done seen", seen, 1'b1);
      end
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
